// File: rtl/sk_add_stream_ctrl.sv
// ---------------------------------------------------------------------------
// sk_add_stream_ctrl
//
// Valid/ready stream wrapper around an external fixed-latency pipelined
// Sklansky adder. Operands are passed straight through to the adder. A
// LAT-bit shift register follows each accepted beat down the adder pipeline.
// When a beat reaches the end of that register, the adder result is written
// into a small result FIFO.
//
// Credits: in_ready is asserted only while (FIFO count + beats in flight) is
// below DEPTH. Every accepted beat therefore already owns a FIFO slot, and
// downstream backpressure can never drop a result.
//
// Parameters
//   WIDTH : operand / sum width
//   LAT   : adder latency in clock edges, from operand capture until the sum
//           is sampled (>= 1)
//   DEPTH : result FIFO entries. Must be >= LAT+2 for full throughput, and
//           need not be a power of two.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand stream handshake
//   in_a, in_b, in_cin   : operands and carry-in
//   add_a, add_b, add_cin: operands driven to the adder (combinational copy)
//   add_sum, add_cout    : adder result, LAT edges after capture
//   out_valid / out_ready: result stream handshake
//   out_sum, out_cout    : FIFO head result (0 while the FIFO is empty)
//   occupancy            : FIFO count plus results still in flight
// ---------------------------------------------------------------------------
module sk_add_stream_ctrl #(
    parameter int WIDTH = 64,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       in_cin,

    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    output logic                       add_cin,
    input  logic [WIDTH-1:0]           add_sum,
    input  logic                       add_cout,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic                       out_cout,

    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [LAT-1:0]   inflight_reg;          // one bit per adder stage
    logic [WIDTH:0]   mem [DEPTH];           // {cout, sum} per entry
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_next;

    logic [CNT_W-1:0] inflight_cnt;
    logic             issue;
    logic             wr_en;
    logic             rd_en;

    // -----------------------------------------------------------------------
    // Adder feed: pure pass-through. The adder output is used only in cycles
    // where a tracked beat reaches the last stage.
    // -----------------------------------------------------------------------
    assign add_a   = in_a;
    assign add_b   = in_b;
    assign add_cin = in_cin;

    assign issue = in_valid & in_ready;
    assign wr_en = inflight_reg[LAT-1];
    assign rd_en = out_valid & out_ready;

    // -----------------------------------------------------------------------
    // In-flight tracking. Bit 0 is set on the issue edge. Bit LAT-1 is high
    // during the cycle before the edge where the adder result is sampled.
    // -----------------------------------------------------------------------
    generate
        if (LAT == 1) begin : g_sr_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    inflight_reg <= '0;
                end else begin
                    inflight_reg[0] <= issue;
                end
            end
        end else begin : g_sr_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    inflight_reg <= '0;
                end else begin
                    inflight_reg <= {inflight_reg[LAT-2:0], issue};
                end
            end
        end
    endgenerate

    always_comb begin
        inflight_cnt = '0;
        for (int k = 0; k < LAT; k++) begin
            inflight_cnt = inflight_cnt + CNT_W'(inflight_reg[k]);
        end
    end

    // -----------------------------------------------------------------------
    // Credit accounting. in_ready depends on registered state only, so there
    // is no combinational path from out_ready or in_valid.
    // -----------------------------------------------------------------------
    assign occupancy = count_reg + inflight_cnt;
    assign in_ready  = (occupancy < CNT_FULL);

    // -----------------------------------------------------------------------
    // Result FIFO. Pointers wrap explicitly at DEPTH-1, so any depth works.
    // -----------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_next = wr_en ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = rd_en ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;   // idle, or write+pop together
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is not reset. Stale entries are never visible, because the
    // head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {add_cout, add_sum};
        end
    end

    // Head output. A write into an empty FIFO becomes visible only after the
    // count register updates; there is no write-to-read bypass.
    assign out_valid = (count_reg != '0);
    assign {out_cout, out_sum} = out_valid ? mem[rd_ptr_reg] : '0;

    // -----------------------------------------------------------------------
    // Simulation checks. The credit scheme makes these unreachable; a firing
    // check means a design error.
    // -----------------------------------------------------------------------
`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && !rd_en && (count_reg == CNT_FULL)))
        else $error("sk_add_stream_ctrl: result FIFO overflow");

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_en && (count_reg == '0)))
        else $error("sk_add_stream_ctrl: result FIFO underflow");

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (occupancy <= CNT_FULL))
        else $error("sk_add_stream_ctrl: occupancy exceeds DEPTH");
`endif

endmodule

// File: tb/tb_sk_add_stream_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for sk_add_stream_ctrl. A behavioural LAT-stage adder model
// closes the add_* loop. A scoreboard queue, fed by the input handshake,
// checks every popped result for value and order. Directed table vectors and
// hand-written sequences cover latency, backpressure, the full/concurrent
// case, throughput and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_sk_add_stream_ctrl;

    localparam int WIDTH = 64;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic [OCC_W-1:0] occupancy;

    sk_add_stream_ctrl #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder: LAT register stages, result sampled LAT edges later
    logic [WIDTH:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign {add_cout, add_sum} = pipe[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;
    int pop_cnt  = 0;
    logic [WIDTH:0] exp_q [$];

    task automatic chk(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard. Sampled on the falling edge; inputs change only just after
    // the rising edge, so this sees what the next rising edge will see.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                exp_q.push_back({1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin});
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %h expected none", {out_cout, out_sum});
                end else begin
                    chk("result_order", {out_cout, out_sum}, exp_q.pop_front());
                end
            end
        end
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int pc0;
        int bad;

        tbl[0] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b1};
        tbl[1] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h1, 1'b1};
        tbl[2] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        tbl[4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0};
        tbl[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h8000_0000_0000_0000, 1'b0};
        tbl[6] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0, 1'b1};
        tbl[7] = '{64'hDEAD_BEEF_0000_0000, 64'h2152_4111_0000_0001, 1'b0, 64'h1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", 65'(out_valid), 65'd0);
        chk("rst_occupancy", 65'(occupancy), 65'd0);
        chk("rst_in_ready", 65'(in_ready), 65'd1);
        chk("rst_head", {out_cout, out_sum}, 65'd0);
        rst_n = 1'b1;

        // Single operations: latency, value, hold under stall, pop
        for (int i = 0; i < 8; i++) begin
            in_a = tbl[i].a; in_b = tbl[i].b; in_cin = tbl[i].cin; in_valid = 1'b1;
            step();                                   // issue edge N
            in_valid = 1'b0;
            chk("vec_occ_issue", 65'(occupancy), 65'd1);
            repeat (LAT - 1) step();
            chk("vec_not_yet_valid", 65'(out_valid), 65'd0);
            step();                                   // write edge N+LAT
            chk("vec_valid", 65'(out_valid), 65'd1);
            chk("vec_result", {out_cout, out_sum}, {tbl[i].cout, tbl[i].sum});
            step();
            chk("vec_result_held", {out_cout, out_sum}, {tbl[i].cout, tbl[i].sum});
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("vec_popped", 65'(out_valid), 65'd0);
            chk("vec_occ_empty", 65'(occupancy), 65'd0);
            $display("vector %0d: a=%h b=%h cin=%0d sum=%h cout=%0d",
                     i, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout);
        end

        // Backpressure: 8 offered beats, only DEPTH accepted
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            in_a = 64'(i); in_b = 64'd100; in_cin = 1'b0; in_valid = 1'b1;
            if (in_ready) accepted++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_accepted", 65'(accepted), 65'd4);
        chk("bp_in_ready", 65'(in_ready), 65'd0);
        chk("bp_occupancy", 65'(occupancy), 65'd4);
        chk("bp_head", {out_cout, out_sum}, 65'd100);
        repeat (3) step();
        chk("bp_head_stable", {out_cout, out_sum}, 65'd100);
        pc0 = pop_cnt;
        out_ready = 1'b1;
        repeat (DEPTH + 2) step();
        out_ready = 1'b0;
        chk("bp_drained", 65'(pop_cnt - pc0), 65'd4);
        $display("backpressure: accepted=%0d drained=%0d", accepted, pop_cnt - pc0);

        // Full FIFO, then concurrent pops and new issues
        in_valid = 1'b1;
        for (int i = 0; i < 10 && in_ready; i++) begin
            in_a = 64'(500 + i); in_b = 64'hFFFF_FFFF_FFFF_FFF0; in_cin = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (LAT) step();
        chk("full_occupancy", 65'(occupancy), 65'd4);
        chk("full_in_ready", 65'(in_ready), 65'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_a = 64'(1000 + i); in_b = 64'(i * 3); in_cin = i[0]; in_valid = 1'b1;
            step();
            chk("full_occ_bound", 65'(occupancy <= OCC_W'(DEPTH)), 65'd1);
        end
        chk("full_steady_occ", 65'(occupancy), 65'd3);
        in_valid = 1'b0;
        repeat (DEPTH + LAT + 2) step();
        chk("full_no_loss", 65'(exp_q.size()), 65'd0);
        chk("full_empty", 65'(out_valid), 65'd0);
        $display("full/concurrent: total pops=%0d", pop_cnt);

        // Throughput: 100 back-to-back random ops with out_ready held high
        pc0 = pop_cnt;
        for (int i = 0; i < 100; i++) begin
            in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cin = 1'($urandom);
            in_valid = 1'b1;
            chk("tput_in_ready", 65'(in_ready), 65'd1);
            step();
        end
        in_valid = 1'b0;
        repeat (LAT + 1) step();
        chk("tput_count", 65'(pop_cnt - pc0), 65'd100);
        chk("tput_empty", 65'(out_valid), 65'd0);
        out_ready = 1'b0;
        $display("throughput: %0d results in %0d cycles", pop_cnt - pc0, 100 + LAT + 1);

        // Reset with two results in flight and one in the FIFO
        for (int i = 0; i < 3; i++) begin
            in_a = 64'(7 + i); in_b = 64'd7; in_cin = 1'b0; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("mid_occupancy", 65'(occupancy), 65'd3);
        chk("mid_valid", 65'(out_valid), 65'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 65'(out_valid), 65'd0);
        chk("mid_rst_occ", 65'(occupancy), 65'd0);
        chk("mid_rst_ready", 65'(in_ready), 65'd1);
        chk("mid_rst_head", {out_cout, out_sum}, 65'd0);
        exp_q.delete();
        pc0 = pop_cnt;
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        bad = 0;
        repeat (10) begin
            step();
            if (out_valid) bad++;
        end
        chk("mid_no_ghost_valid", 65'(bad), 65'd0);
        chk("mid_no_ghost_pop", 65'(pop_cnt - pc0), 65'd0);
        $display("reset mid-op: ghost cycles=%0d", bad);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
